// File: rtl/card_game_ctrl.sv
// card_game_ctrl: 4x4 memory-card game controller (cursor, flips, pair compare, mismatch display)
module card_game_ctrl #(
    parameter int SHOW_TICKS = 25_000_000,
    parameter int MOVES_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_sel,
    input  logic               btn_start,
    output logic [3:0]         cursor,
    output logic [15:0]        face_up,
    output logic [15:0]        matched,
    output logic [3:0]         pairs_found,
    output logic [MOVES_W-1:0] moves,
    output logic [3:0]         seed,
    output logic [2:0]         state,
    output logic               game_won
);
    localparam int TW = SHOW_TICKS > 1 ? $clog2(SHOW_TICKS) : 1;
    localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PICK1   = 3'd1,
        PICK2   = 3'd2,
        COMPARE = 3'd3,
        SHOW    = 3'd4,
        WIN     = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cursor_q, cursor_d;
    logic [3:0]         first_q, first_d;
    logic [3:0]         second_q, second_d;
    logic [3:0]         seed_q, seed_d;
    logic [3:0]         free_q, free_d;
    logic [3:0]         pairs_q, pairs_d;
    logic [15:0]        face_q, face_d;
    logic [15:0]        matched_q, matched_d;
    logic [MOVES_W-1:0] moves_q, moves_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [3:0]         sum_first, sum_second, cursor_mv;
    logic [1:0]         row, col;
    logic               pick, same_sym, can_move;

    // Symbol is the top three bits of (position + seed) mod 16, so each pair is two adjacent rotated slots.
    assign sum_first  = first_q + seed_q;
    assign sum_second = second_q + seed_q;
    assign same_sym   = sum_first[3:1] == sum_second[3:1];
    assign pick       = btn_sel && !face_q[cursor_q];
    assign can_move   = state_q == PICK1 || state_q == PICK2 || state_q == SHOW;
    assign row        = cursor_q[3:2];
    assign col        = cursor_q[1:0];
    assign cursor_mv  = btn_up    ? {row - 2'd1, col} :
                        btn_down  ? {row + 2'd1, col} :
                        btn_left  ? {row, col - 2'd1} :
                        btn_right ? {row, col + 2'd1} : cursor_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; start overrides every state
    always_comb begin
        state_d = state_q;
        if (btn_start) state_d = PICK1;
        else begin
            case (state_q)
                PICK1:   if (pick) state_d = PICK2;
                PICK2:   if (pick) state_d = COMPARE;
                COMPARE: state_d = same_sym ? (pairs_q == 4'd7 ? WIN : PICK1) : SHOW;
                SHOW:    if (timer_q == '0) state_d = PICK1;
                default: state_d = state_q;
            endcase
        end
    end

    // Outputs decoded from state
    always_comb begin
        game_won = state_q == WIN;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cursor_q  <= '0;
            first_q   <= '0;
            second_q  <= '0;
            seed_q    <= '0;
            free_q    <= '0;
            pairs_q   <= '0;
            face_q    <= '0;
            matched_q <= '0;
            moves_q   <= '0;
            timer_q   <= '0;
        end else begin
            cursor_q  <= cursor_d;
            first_q   <= first_d;
            second_q  <= second_d;
            seed_q    <= seed_d;
            free_q    <= free_d;
            pairs_q   <= pairs_d;
            face_q    <= face_d;
            matched_q <= matched_d;
            moves_q   <= moves_d;
            timer_q   <= timer_d;
        end
    end

    // Datapath next values; selection always uses the pre-move cursor
    always_comb begin
        free_d    = free_q + 4'd1;
        cursor_d  = cursor_q;
        first_d   = first_q;
        second_d  = second_q;
        seed_d    = seed_q;
        pairs_d   = pairs_q;
        face_d    = face_q;
        matched_d = matched_q;
        moves_d   = moves_q;
        timer_d   = timer_q;
        if (btn_start) begin
            seed_d    = free_q;
            cursor_d  = '0;
            pairs_d   = '0;
            face_d    = '0;
            matched_d = '0;
            moves_d   = '0;
        end else begin
            if (can_move) cursor_d = cursor_mv;
            case (state_q)
                PICK1: if (pick) begin
                    face_d[cursor_q] = 1'b1;
                    first_d          = cursor_q;
                end
                PICK2: if (pick) begin
                    face_d[cursor_q] = 1'b1;
                    second_d         = cursor_q;
                    moves_d          = &moves_q ? moves_q : moves_q + MOVES_W'(1);
                end
                COMPARE: if (same_sym) begin
                    matched_d[first_q]  = 1'b1;
                    matched_d[second_q] = 1'b1;
                    pairs_d             = pairs_q + 4'd1;
                end else timer_d = SHOW_LAST;
                SHOW: if (timer_q == '0) begin
                    face_d[first_q]  = 1'b0;
                    face_d[second_q] = 1'b0;
                end else timer_d = timer_q - TW'(1);
                default: timer_d = timer_q;
            endcase
        end
    end

    assign cursor      = cursor_q;
    assign face_up     = face_q;
    assign matched     = matched_q;
    assign pairs_found = pairs_q;
    assign moves       = moves_q;
    assign seed        = seed_q;
    assign state       = state_q;
endmodule

// File: tb/tb_card_game_ctrl.sv
// tb_card_game_ctrl: vector table, directed game sequences and random play against a reference model
module tb_card_game_ctrl;
    localparam int SHOW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic        btn_sel = 1'b0, btn_start = 1'b0;
    logic [3:0]  cursor, pairs_found, seed;
    logic [15:0] face_up, matched;
    logic [7:0]  moves;
    logic [2:0]  state;
    logic        game_won;

    card_game_ctrl #(.SHOW_TICKS(SHOW), .MOVES_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_sel(btn_sel), .btn_start(btn_start),
        .cursor(cursor), .face_up(face_up), .matched(matched), .pairs_found(pairs_found),
        .moves(moves), .seed(seed), .state(state), .game_won(game_won)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model of the game, in plain integers and arrays
    int m_state, m_cur, m_pairs, m_moves, m_seed, m_free, m_timer, m_first, m_second;
    bit m_face[16];
    bit m_mat[16];

    function automatic int sym(int p, int s);
        return ((p + s) % 16) / 2;
    endfunction

    function automatic int pack(bit a[16]);
        int v = 0;
        for (int i = 0; i < 16; i++) if (a[i]) v += 1 << i;
        return v;
    endfunction

    task automatic model_step(input logic r, input logic [5:0] b);
        int row, col, cur, fprev;
        bit st, sl, u, d, l, rt;
        {st, sl, u, d, l, rt} = b;
        if (!r) begin
            m_state = 0; m_cur = 0; m_pairs = 0; m_moves = 0; m_seed = 0;
            m_free = 0; m_timer = 0; m_first = 0; m_second = 0;
            for (int i = 0; i < 16; i++) begin m_face[i] = 0; m_mat[i] = 0; end
            return;
        end
        cur = m_cur;
        fprev = m_free;
        m_free = (m_free + 1) % 16;
        if (st) begin
            m_seed = fprev; m_cur = 0; m_pairs = 0; m_moves = 0; m_state = 1;
            for (int i = 0; i < 16; i++) begin m_face[i] = 0; m_mat[i] = 0; end
            return;
        end
        if (m_state == 1 || m_state == 2 || m_state == 4) begin
            row = cur / 4;
            col = cur % 4;
            if (u) row = (row + 3) % 4;
            else if (d) row = (row + 1) % 4;
            else if (l) col = (col + 3) % 4;
            else if (rt) col = (col + 1) % 4;
            m_cur = row * 4 + col;
        end
        case (m_state)
            1: if (sl && !m_face[cur]) begin
                m_face[cur] = 1; m_first = cur; m_state = 2;
            end
            2: if (sl && !m_face[cur]) begin
                m_face[cur] = 1; m_second = cur; m_state = 3;
                if (m_moves < 255) m_moves++;
            end
            3: if (sym(m_first, m_seed) == sym(m_second, m_seed)) begin
                m_mat[m_first] = 1; m_mat[m_second] = 1; m_pairs++;
                m_state = m_pairs == 8 ? 5 : 1;
            end else begin
                m_timer = SHOW - 1; m_state = 4;
            end
            4: if (m_timer == 0) begin
                m_face[m_first] = 0; m_face[m_second] = 0; m_state = 1;
            end else m_timer--;
            default: ;
        endcase
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".state"}, int'(state), m_state);
        chk({tag, ".cursor"}, int'(cursor), m_cur);
        chk({tag, ".face_up"}, int'(face_up), pack(m_face));
        chk({tag, ".matched"}, int'(matched), pack(m_mat));
        chk({tag, ".pairs"}, int'(pairs_found), m_pairs);
        chk({tag, ".moves"}, int'(moves), m_moves);
        chk({tag, ".seed"}, int'(seed), m_seed);
        chk({tag, ".game_won"}, int'(game_won), m_state == 5 ? 1 : 0);
    endtask

    // drive one cycle from a falling edge, advance the model at the rising edge, sample at the next falling edge
    task automatic cycle(input logic r, input logic [5:0] b);
        rst_n = r;
        {btn_start, btn_sel, btn_up, btn_down, btn_left, btn_right} = b;
        @(posedge clk);
        model_step(r, b);
        @(negedge clk);
        {btn_start, btn_sel, btn_up, btn_down, btn_left, btn_right} = '0;
    endtask

    task automatic move_to(input int t, input string tag);
        int guard = 0;
        while (m_cur != t && guard < 12) begin
            cycle(1'b1, (m_cur / 4 != t / 4) ? 6'd4 : 6'd1);
            check_model(tag);
            guard++;
        end
        chk({tag, ".reach"}, int'(cursor), t);
    endtask

    typedef struct {
        logic       rst;
        logic [5:0] b;
        int         st, cur, face, mat, pairs, moves;
    } vec_t;

    function automatic vec_t v(logic r, logic [5:0] b, int st, int cur, int face, int mat, int pairs, int mv);
        vec_t x;
        x.rst = r; x.b = b; x.st = st; x.cur = cur; x.face = face; x.mat = mat; x.pairs = pairs; x.moves = mv;
        return x;
    endfunction

    // buttons: {start, sel, up, down, left, right}
    vec_t tbl[36];
    int s;

    initial begin
        for (int i = 0; i < 5; i++) tbl[i] = v(0, 6'd0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = v(1, 6'd32, 1, 0, 'h0000, 'h0000, 0, 0);
        tbl[6]  = v(1, 6'd16, 2, 0, 'h0001, 'h0000, 0, 0);
        tbl[7]  = v(1, 6'd1,  2, 1, 'h0001, 'h0000, 0, 0);
        tbl[8]  = v(1, 6'd16, 3, 1, 'h0003, 'h0000, 0, 1);
        tbl[9]  = v(1, 6'd0,  1, 1, 'h0003, 'h0003, 1, 1);
        tbl[10] = v(1, 6'd1,  1, 2, 'h0003, 'h0003, 1, 1);
        tbl[11] = v(1, 6'd16, 2, 2, 'h0007, 'h0003, 1, 1);
        tbl[12] = v(1, 6'd4,  2, 6, 'h0007, 'h0003, 1, 1);
        tbl[13] = v(1, 6'd2,  2, 5, 'h0007, 'h0003, 1, 1);
        tbl[14] = v(1, 6'd2,  2, 4, 'h0007, 'h0003, 1, 1);
        tbl[15] = v(1, 6'd16, 3, 4, 'h0017, 'h0003, 1, 2);
        tbl[16] = v(1, 6'd0,  4, 4, 'h0017, 'h0003, 1, 2);
        tbl[17] = v(1, 6'd16, 4, 4, 'h0017, 'h0003, 1, 2);
        tbl[18] = v(1, 6'd17, 4, 5, 'h0017, 'h0003, 1, 2);
        tbl[19] = v(1, 6'd10, 4, 1, 'h0017, 'h0003, 1, 2);
        tbl[20] = v(1, 6'd0,  1, 1, 'h0003, 'h0003, 1, 2);
        tbl[21] = v(1, 6'd16, 1, 1, 'h0003, 'h0003, 1, 2);
        tbl[22] = v(1, 6'd2,  1, 0, 'h0003, 'h0003, 1, 2);
        tbl[23] = v(1, 6'd8,  1, 12, 'h0003, 'h0003, 1, 2);
        tbl[24] = v(1, 6'd4,  1, 0, 'h0003, 'h0003, 1, 2);
        tbl[25] = v(1, 6'd2,  1, 3, 'h0003, 'h0003, 1, 2);
        tbl[26] = v(1, 6'd1,  1, 0, 'h0003, 'h0003, 1, 2);
        tbl[27] = v(1, 6'd1,  1, 1, 'h0003, 'h0003, 1, 2);
        tbl[28] = v(1, 6'd1,  1, 2, 'h0003, 'h0003, 1, 2);
        tbl[29] = v(1, 6'd16, 2, 2, 'h0007, 'h0003, 1, 2);
        tbl[30] = v(1, 6'd16, 2, 2, 'h0007, 'h0003, 1, 2);
        tbl[31] = v(1, 6'd5,  2, 6, 'h0007, 'h0003, 1, 2);
        tbl[32] = v(1, 6'd8,  2, 2, 'h0007, 'h0003, 1, 2);
        tbl[33] = v(1, 6'd1,  2, 3, 'h0007, 'h0003, 1, 2);
        tbl[34] = v(1, 6'd16, 3, 3, 'h000F, 'h0003, 1, 3);
        tbl[35] = v(1, 6'd17, 1, 3, 'h000F, 'h000F, 2, 3);

        model_step(1'b0, 6'd0);
        @(negedge clk);
        for (int i = 0; i < 36; i++) begin
            cycle(tbl[i].rst, tbl[i].b);
            chk($sformatf("vec%0d.state", i), int'(state), tbl[i].st);
            chk($sformatf("vec%0d.cursor", i), int'(cursor), tbl[i].cur);
            chk($sformatf("vec%0d.face_up", i), int'(face_up), tbl[i].face);
            chk($sformatf("vec%0d.matched", i), int'(matched), tbl[i].mat);
            chk($sformatf("vec%0d.pairs", i), int'(pairs_found), tbl[i].pairs);
            chk($sformatf("vec%0d.moves", i), int'(moves), tbl[i].moves);
            chk($sformatf("vec%0d.seed", i), int'(seed), 0);
            chk($sformatf("vec%0d.game_won", i), int'(game_won), 0);
        end

        // full game with seed 0: pairs (0,1),(2,3)...(14,15)
        cycle(1'b0, 6'd0);
        cycle(1'b1, 6'd32);
        chk("game.seed", int'(seed), 0);
        for (int k = 0; k < 8; k++) begin
            move_to(2 * k, "game.mv");
            cycle(1'b1, 6'd16);
            check_model("game.sel1");
            move_to(2 * k + 1, "game.mv");
            cycle(1'b1, 6'd16);
            check_model("game.sel2");
            cycle(1'b1, 6'd0);
            check_model("game.cmp");
        end
        chk("win.state", int'(state), 5);
        chk("win.pairs", int'(pairs_found), 8);
        chk("win.moves", int'(moves), 8);
        chk("win.matched", int'(matched), 'hFFFF);
        chk("win.face_up", int'(face_up), 'hFFFF);
        chk("win.game_won", int'(game_won), 1);
        cycle(1'b1, 6'b011111);
        chk("win.hold_state", int'(state), 5);
        chk("win.hold_cursor", int'(cursor), 15);

        // restart from WIN, then reset in the middle of a mismatch display
        s = m_free;
        cycle(1'b1, 6'd32);
        chk("restart.seed", int'(seed), s);
        chk("restart.state", int'(state), 1);
        chk("restart.face_up", int'(face_up), 0);
        chk("restart.matched", int'(matched), 0);
        chk("restart.moves", int'(moves), 0);
        chk("restart.pairs", int'(pairs_found), 0);
        chk("restart.cursor", int'(cursor), 0);
        cycle(1'b1, 6'd16);
        move_to(2, "midshow.mv");
        cycle(1'b1, 6'd16);
        cycle(1'b1, 6'd0);
        chk("midshow.state", int'(state), 4);
        chk("midshow.face_up", int'(face_up), 'h0005);
        cycle(1'b1, 6'd0);
        cycle(1'b0, 6'd0);
        chk("midshow_rst.state", int'(state), 0);
        chk("midshow_rst.face_up", int'(face_up), 0);
        chk("midshow_rst.moves", int'(moves), 0);
        chk("midshow_rst.seed", int'(seed), 0);
        chk("midshow_rst.cursor", int'(cursor), 0);
        chk("midshow_rst.game_won", int'(game_won), 0);

        // random play against the model
        for (int i = 0; i < 4000; i++) begin
            logic r;
            logic [5:0] b;
            r = $urandom_range(199) != 0;
            b[5] = $urandom_range(59) == 0;
            b[4] = $urandom_range(2) == 0;
            b[3] = $urandom_range(4) == 0;
            b[2] = $urandom_range(4) == 0;
            b[1] = $urandom_range(4) == 0;
            b[0] = $urandom_range(4) == 0;
            cycle(r, b);
            check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/card_game_ctrl.md
Name: card_game_ctrl

Overview:
- Game controller for the 4x4 memory-card board.
- Owns cursor, per-card face-up/matched state, pair comparison and mismatch display timing.
- Outputs drive the per-position card renderers: `face_up[i]` enables card i's face, and `cursor` highlights the selected position.
- Position index `p = {row[1:0], col[1:0]}`; p=0 is top-left, p=3 is top-right, p=12 is bottom-left.

Parameters:
- SHOW_TICKS, 25_000_000, clock cycles a mismatched pair stays face-up; must be >= 1.
- MOVES_W, 8, width of the saturating move counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- btn_up  in  1  single-cycle pulse, cursor row-1.
- btn_down  in  1  single-cycle pulse, cursor row+1.
- btn_left  in  1  single-cycle pulse, cursor col-1.
- btn_right  in  1  single-cycle pulse, cursor col+1.
- btn_sel  in  1  single-cycle pulse, flip card under cursor.
- btn_start  in  1  single-cycle pulse, start or restart a game.
- cursor  out  4  current cursor position.
- face_up  out  16  bit i=1: card i is shown face-up (includes matched cards).
- matched  out  16  bit i=1: card i is permanently matched.
- pairs_found  out  4  number of matched pairs, 0..8.
- moves  out  MOVES_W  completed pair attempts, saturating at all-ones.
- seed  out  4  layout seed latched at game start.
- state  out  3  IDLE=0, PICK1=1, PICK2=2, COMPARE=3, SHOW=4, WIN=5.
- game_won  out  1  high while in WIN.

Behaviour:
- **Reset** (rst_n=0 at a clk edge), synchronous, usable at any time including mid-SHOW:
  - state=IDLE.
  - cursor, face_up, matched, pairs_found, moves, seed, free_cnt and timer all 0.
  - game_won=0.
- **free_cnt**: 4-bit counter, increments every cycle that rst_n=1, wraps 15->0.
- **Symbol of position p**: `sym(p) = ((p + seed) mod 16) >> 1` (3 bits). Cards match iff their symbols are equal, giving exactly 8 pairs for any seed.
- **Start**:
  - btn_start has top priority in every state.
  - Next cycle: seed=free_cnt, face_up=0, matched=0, pairs_found=0, moves=0, cursor=0, state=PICK1.
  - All other inputs in that cycle are ignored.
- **Cursor**:
  - Moves in PICK1, PICK2 and SHOW; frozen in IDLE, COMPARE and WIN.
  - One move per cycle, priority up > down > left > right.
  - Row and column wrap mod 4 independently: right from col 3 goes to col 0 of the same row; up from row 0 goes to row 3.
  - Updates the cycle after the pulse.
- **Selection vs. movement in the same cycle**: the selection applies to the pre-move cursor.
- **PICK1**: btn_sel with face_up[cursor]=0 -> next cycle face_up[cursor]=1, first=cursor, state=PICK2. btn_sel on a face-up card is ignored.
- **PICK2**: btn_sel with face_up[cursor]=0 -> next cycle:
  - face_up[cursor]=1, second=cursor.
  - moves+1, saturating.
  - state=COMPARE.
  - Selecting the first card again is ignored, since it is already face-up.
- **COMPARE** (exactly 1 cycle):
  - If sym(first)==sym(second): matched[first]=matched[second]=1 and pairs_found+1. Then state=WIN if the new pairs_found==8, else PICK1.
  - Otherwise: timer=SHOW_TICKS-1, state=SHOW.
  - btn_sel is ignored in this cycle.
- **SHOW**:
  - btn_sel is ignored.
  - When timer==0: face_up[first]=face_up[second]=0, state=PICK1. Otherwise timer-1.
  - Both cards are therefore visible in SHOW for exactly SHOW_TICKS cycles.
- **WIN**: game_won=1, face_up=matched=all ones; only btn_start (restart) or reset leaves WIN.
- **IDLE**: all inputs except btn_start are ignored.
- **Invariants**:
  - matched is a subset of face_up.
  - popcount(matched) = 2 * pairs_found.
  - In PICK1, face_up==matched.

Test Plan:
1. **Reset and start.** Reset, hold 5 cycles, release, pulse btn_start when free_cnt=0 -> seed=0, state=PICK1, face_up=0, cursor=0.
2. **Match.**
   - Setup: seed=0, sel at p=0, btn_right, sel at p=1.
   - Response: face_up=0x0003 one cycle after the second sel; one cycle later (COMPARE done) matched=0x0003, pairs_found=1, moves=1, state=PICK1.
3. **Mismatch timing.**
   - Setup: SHOW_TICKS=4, seed=0, sel p=0, then sel p=2.
   - Response: state=SHOW for exactly 4 cycles with face_up=0x0005, then face_up=0, state=PICK1, moves=1.
4. **Wrap, priority and ignored selects.**
   - cursor=3, btn_right -> cursor=0.
   - btn_up at cursor=0 -> cursor=12.
   - btn_up+btn_left together at cursor=5 -> cursor=1.
   - sel on an already face-up card -> no state or moves change.
5. **Full game.** seed=0, select pairs (0,1),(2,3)…(14,15) -> pairs_found=8, moves=8, state=WIN, game_won=1, matched=0xFFFF.
6. **Restart and mid-game reset.**
   - btn_start in WIN -> all cleared, new seed=free_cnt, state=PICK1.
   - rst_n=0 mid-SHOW -> next cycle all outputs 0, state=IDLE.
